// File: rtl/vedic_mac_acc.sv
// vedic_mac_acc: pipelined multiply-accumulate over packets of 32x32 unsigned operand pairs.
//   S1 registers operands, S2 registers the 64-bit vedic_32x32 product, S3 accumulates.
//   One result per packet (in_last marks the final beat), presented via valid/ready.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        operand beat handshake (in_ready = global pipeline enable)
//   in_a, in_b, in_last      operands and end-of-packet marker
//   out_valid/out_ready      result handshake; result held while out_ready is low
//   out_acc                  packet sum of products, modulo 2**ACC_W
//   out_count                beats in the packet, saturating at 2**CNT_W-1
//   out_ovf                  a carry out of ACC_W occurred within the packet

// vedic_32x32: combinational 32x32 unsigned multiplier built from vertical-and-crosswise
// partial products (32 -> 16 -> 8 bit halves).
module vedic_32x32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);

  // 8x8 leaf product
  function automatic logic [15:0] vm8(input logic [7:0] x, input logic [7:0] y);
    return 16'(x) * 16'(y);
  endfunction

  // 16x16 from four 8x8 partial products; crosswise terms summed before shifting
  function automatic logic [31:0] vm16(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] ll, lh, hl, hh;
    logic [16:0] mid;
    ll  = vm8(x[7:0],  y[7:0]);
    lh  = vm8(x[7:0],  y[15:8]);
    hl  = vm8(x[15:8], y[7:0]);
    hh  = vm8(x[15:8], y[15:8]);
    mid = 17'(lh) + 17'(hl);
    return 32'(ll) + (32'(mid) << 8) + (32'(hh) << 16);
  endfunction

  // 32x32 from four 16x16 partial products
  function automatic logic [63:0] vm32(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] ll, lh, hl, hh;
    logic [32:0] mid;
    ll  = vm16(x[15:0],  y[15:0]);
    lh  = vm16(x[15:0],  y[31:16]);
    hl  = vm16(x[31:16], y[15:0]);
    hh  = vm16(x[31:16], y[31:16]);
    mid = 33'(lh) + 33'(hl);
    return 64'(ll) + (64'(mid) << 16) + (64'(hh) << 32);
  endfunction

  always_comb begin
    p = vm32(a, b);
  end

endmodule

module vedic_mac_acc #(
  parameter int unsigned ACC_W = 72,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic             en;
  logic             s1_v, s1_last;
  logic [31:0]      s1_a, s1_b;
  logic             s2_v, s2_last;
  logic [63:0]      s2_p;
  logic [63:0]      prod;

  logic [1:0]       state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ovf, ovf_nx;
  logic             out_valid_nx;
  logic [ACC_W-1:0] out_acc_nx;
  logic [CNT_W-1:0] out_count_nx;
  logic             out_ovf_nx;

  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] cnt_inc;

  // Whole pipeline freezes while a result waits for downstream
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  vedic_32x32 u_mul (
    .a (s1_a),
    .b (s1_b),
    .p (prod)
  );

  // S1 operand register and S2 product register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_a    <= 32'd0;
      s1_b    <= 32'd0;
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      s2_p    <= 64'd0;
    end else if (en) begin
      s1_v    <= in_valid;
      s1_last <= in_last;
      s1_a    <= in_a;
      s1_b    <= in_b;
      s2_v    <= s1_v;
      s2_last <= s1_last;
      s2_p    <= prod;
    end
  end

  // Accumulator FSM state and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      ovf       <= ovf_nx;
      out_valid <= out_valid_nx;
      out_acc   <= out_acc_nx;
      out_count <= out_count_nx;
      out_ovf   <= out_ovf_nx;
    end
  end

  // Next-state: acc/cnt/ovf are zero in IDLE and HOLD, so one add path serves
  // first beats, continuing beats and back-to-back packet starts alike.
  always_comb begin
    state_nx     = state;
    acc_nx       = acc;
    cnt_nx       = cnt;
    ovf_nx       = ovf;
    out_valid_nx = out_valid;
    out_acc_nx   = out_acc;
    out_count_nx = out_count;
    out_ovf_nx   = out_ovf;

    sum     = {1'b0, acc} + {1'b0, ACC_W'(s2_p)};
    cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

    if (en) begin
      if (s2_v) begin
        if (s2_last) begin
          state_nx     = HOLD;
          out_valid_nx = 1'b1;
          out_acc_nx   = sum[ACC_W-1:0];
          out_count_nx = cnt_inc;
          out_ovf_nx   = ovf | sum[ACC_W];
          acc_nx       = '0;
          cnt_nx       = '0;
          ovf_nx       = 1'b0;
        end else begin
          state_nx     = ACCUM;
          out_valid_nx = 1'b0;
          acc_nx       = sum[ACC_W-1:0];
          cnt_nx       = cnt_inc;
          ovf_nx       = ovf | sum[ACC_W];
        end
      end else if (state == HOLD) begin
        state_nx     = IDLE;
        out_valid_nx = 1'b0;
      end
    end
  end

endmodule
